// File: rtl/cache_pkg.sv
// Shared geometry, widths and FSM encoding for the cache refill controller.
package cache_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 8;
  localparam int unsigned WORDS = 4;

  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned SetW  = $clog2(SETS);
  localparam int unsigned WordW = $clog2(WORDS);

  typedef logic [WayW-1:0]  way_t;
  typedef logic [SetW-1:0]  set_t;
  typedef logic [WordW-1:0] word_t;

  typedef enum logic [1:0] {StIdle, StFill, StTag} state_e;

  // New age of one way when another (or the same) way in its set is touched.
  function automatic way_t touched_age(way_t age, way_t tgt_age, logic is_tgt);
    if (is_tgt) begin
      return '0;
    end else if (age < tgt_age) begin
      return age + 1'b1;
    end
    return age;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss/hit, memory-fetch and register-write signals of the refill controller.
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  logic        miss_req;
  set_t        miss_set;
  logic        miss_ack;
  logic        hit_valid;
  set_t        hit_set;
  way_t        hit_way;
  logic        mem_req;
  word_t       mem_word;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        regWrite;
  set_t        wr_set;
  way_t        wr_way;
  word_t       wr_word;
  logic [31:0] wr_data;
  logic        tag_write;
  logic        done;

  modport master (
    output miss_req, miss_set, hit_valid, hit_set, hit_way, mem_valid, mem_data,
    input  miss_ack, mem_req, mem_word, regWrite, wr_set, wr_way, wr_word, wr_data,
    input  tag_write, done
  );

  modport slave (
    input  miss_req, miss_set, hit_valid, hit_set, hit_way, mem_valid, mem_data,
    output miss_ack, mem_req, mem_word, regWrite, wr_set, wr_way, wr_word, wr_data,
    output tag_write, done
  );

endinterface

// File: rtl/cache_lru_ages.sv
// Per-set true-LRU age array; each set holds a permutation of 0..WAYS-1.
module cache_lru_ages
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fill_en_i,
  input  set_t fill_set_i,
  input  way_t fill_way_i,
  input  logic hit_en_i,
  input  set_t hit_set_i,
  input  way_t hit_way_i,
  input  set_t lookup_set_i,
  output way_t victim_o
);

  way_t ages_q [SETS][WAYS];
  way_t ages_d [SETS][WAYS];
  logic touch_en;
  way_t touch_way;

  // A fill touch on the same set as a hit takes priority and the hit is dropped.
  always_comb begin
    ages_d    = ages_q;
    touch_en  = 1'b0;
    touch_way = '0;
    for (int s = 0; s < SETS; s++) begin
      touch_en  = 1'b0;
      touch_way = '0;
      if (fill_en_i && (fill_set_i == set_t'(s))) begin
        touch_en  = 1'b1;
        touch_way = fill_way_i;
      end else if (hit_en_i && (hit_set_i == set_t'(s))) begin
        touch_en  = 1'b1;
        touch_way = hit_way_i;
      end
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          ages_d[s][w] = touched_age(ages_q[s][w], ages_q[s][touch_way],
                                     way_t'(w) == touch_way);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ages_q[s][w] <= way_t'(w);
        end
      end
    end else begin
      ages_q <= ages_d;
    end
  end

  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_q[lookup_set_i][w] == way_t'(WAYS - 1)) begin
        victim_o = way_t'(w);
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill controller: picks an LRU victim on a miss, fetches the block word by
// word and drives the data-register and tag write strobes.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  cache_refill_ctrl_if.slave bus
);

  localparam word_t LastWord = word_t'(WORDS - 1);

  state_e      state_q;
  logic        mem_req_q;
  word_t       mem_word_q;
  logic        reg_write_q;
  set_t        wr_set_q;
  way_t        wr_way_q;
  word_t       wr_word_q;
  logic [31:0] wr_data_q;
  logic        tag_write_q;
  logic        done_q;
  way_t        victim;

  assign bus.miss_ack  = (state_q == StIdle) && bus.miss_req && rst_n;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_word  = mem_word_q;
  assign bus.regWrite  = reg_write_q;
  assign bus.wr_set    = wr_set_q;
  assign bus.wr_way    = wr_way_q;
  assign bus.wr_word   = wr_word_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.tag_write = tag_write_q;
  assign bus.done      = done_q;

  cache_lru_ages u_lru (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_en_i    (state_q == StTag),
    .fill_set_i   (wr_set_q),
    .fill_way_i   (wr_way_q),
    .hit_en_i     (bus.hit_valid),
    .hit_set_i    (bus.hit_set),
    .hit_way_i    (bus.hit_way),
    .lookup_set_i (bus.miss_set),
    .victim_o     (victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_word_q  <= '0;
      reg_write_q <= 1'b0;
      wr_set_q    <= '0;
      wr_way_q    <= '0;
      wr_word_q   <= '0;
      wr_data_q   <= '0;
      tag_write_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      tag_write_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Victim comes from the ages before any same-cycle hit touch.
          if (bus.miss_req) begin
            state_q    <= StFill;
            wr_set_q   <= bus.miss_set;
            wr_way_q   <= victim;
            mem_word_q <= '0;
            mem_req_q  <= 1'b1;
          end
        end
        StFill: begin
          if (bus.mem_valid) begin
            reg_write_q <= 1'b1;
            wr_data_q   <= bus.mem_data;
            wr_word_q   <= mem_word_q;
            mem_word_q  <= mem_word_q + 1'b1;
            if (mem_word_q == LastWord) begin
              state_q     <= StTag;
              mem_req_q   <= 1'b0;
              tag_write_q <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
        StTag: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: vector table for the first refill,
// hand sequences for LRU ordering, stalls, held misses, hit collisions and reset.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus_if ();

  cache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic        miss_req;
    set_t        miss_set;
    logic        mem_valid;
    logic [31:0] mem_data;
  } in_t;

  typedef struct packed {
    logic        ack;
    logic        mreq;
    word_t       mword;
    logic        rw;
    set_t        wset;
    way_t        wway;
    word_t       wword;
    logic [31:0] wdata;
    logic        tag;
    logic        done;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic out_t observe();
    out_t o;
    o.ack   = bus_if.miss_ack;
    o.mreq  = bus_if.mem_req;
    o.mword = bus_if.mem_word;
    o.rw    = bus_if.regWrite;
    o.wset  = bus_if.wr_set;
    o.wway  = bus_if.wr_way;
    o.wword = bus_if.wr_word;
    o.wdata = bus_if.wr_data;
    o.tag   = bus_if.tag_write;
    o.done  = bus_if.done;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full refill starting in IDLE; optional stall before word 1, hit in the
  // TAG cycle, and a second miss held high for the whole refill.
  task automatic do_refill(input set_t s, input way_t exp_way, input logic [31:0] base,
                           input int gap, input logic tag_hit, input set_t hs,
                           input way_t hw, input logic hold, input set_t hold_set);
    int          k;
    int          g;
    logic        mv;
    logic        pend;
    int          pend_word;
    logic [31:0] pend_data;
    bus_if.miss_req  = 1'b1;
    bus_if.miss_set  = s;
    bus_if.mem_valid = 1'b0;
    @(negedge clk);
    chk("accept_ack", 64'(bus_if.miss_ack), 64'd1);
    next_cycle();
    bus_if.miss_req = hold;
    bus_if.miss_set = hold_set;
    k = 0;
    g = gap;
    pend = 1'b0;
    pend_word = 0;
    pend_data = '0;
    while (k < WORDS) begin
      mv = !(k == 1 && g > 0);
      if (!mv) g--;
      bus_if.mem_valid = mv;
      bus_if.mem_data  = mv ? base + 32'(k) : 32'hBAD0_0000 + 32'(g);
      @(negedge clk);
      chk("fill_mem_req", 64'(bus_if.mem_req), 64'd1);
      chk("fill_mem_word", 64'(bus_if.mem_word), 64'(k));
      chk("fill_regwrite", 64'(bus_if.regWrite), 64'(pend));
      if (pend) begin
        chk("fill_wr_word", 64'(bus_if.wr_word), 64'(pend_word));
        chk("fill_wr_data", 64'(bus_if.wr_data), 64'(pend_data));
      end
      chk("fill_wr_set", 64'(bus_if.wr_set), 64'(s));
      chk("fill_wr_way", 64'(bus_if.wr_way), 64'(exp_way));
      chk("fill_tag_done", {bus_if.tag_write, bus_if.done}, 64'd0);
      chk("fill_no_ack", 64'(bus_if.miss_ack), 64'd0);
      next_cycle();
      pend = mv;
      if (mv) begin
        pend_word = k;
        pend_data = base + 32'(k);
        k++;
      end
    end
    bus_if.mem_valid = 1'b1;
    bus_if.mem_data  = 32'hFEED_F00D;
    bus_if.hit_valid = tag_hit;
    bus_if.hit_set   = hs;
    bus_if.hit_way   = hw;
    @(negedge clk);
    chk("tag_tag_done", {bus_if.tag_write, bus_if.done}, 64'd3);
    chk("tag_mem_req", 64'(bus_if.mem_req), 64'd0);
    chk("tag_regwrite", 64'(bus_if.regWrite), 64'd1);
    chk("tag_wr_word", 64'(bus_if.wr_word), 64'(WORDS - 1));
    chk("tag_wr_data", 64'(bus_if.wr_data), 64'(base + 32'(WORDS - 1)));
    chk("tag_wr_way", 64'(bus_if.wr_way), 64'(exp_way));
    chk("tag_no_ack", 64'(bus_if.miss_ack), 64'd0);
    next_cycle();
    bus_if.mem_valid = 1'b0;
    bus_if.hit_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bus_if.miss_req  = 1'b1;
    bus_if.miss_set  = 3'd6;
    bus_if.hit_valid = 1'b0;
    bus_if.hit_set   = '0;
    bus_if.hit_way   = '0;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_data  = 32'h1234_5678;

    // Baseline refill of set 2 from reset: victim way 3, continuous mem_valid.
    vecs[0] = '{'{1'b1, 3'd2, 1'b0, 32'h0},
                '{1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h0, 1'b0, 1'b0}};
    vecs[1] = '{'{1'b0, 3'd0, 1'b1, 32'hA0},
                '{1'b0, 1'b1, 2'd0, 1'b0, 3'd2, 2'd3, 2'd0, 32'h0, 1'b0, 1'b0}};
    vecs[2] = '{'{1'b0, 3'd0, 1'b1, 32'hA1},
                '{1'b0, 1'b1, 2'd1, 1'b1, 3'd2, 2'd3, 2'd0, 32'hA0, 1'b0, 1'b0}};
    vecs[3] = '{'{1'b0, 3'd0, 1'b1, 32'hA2},
                '{1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 2'd3, 2'd1, 32'hA1, 1'b0, 1'b0}};
    vecs[4] = '{'{1'b0, 3'd0, 1'b1, 32'hA3},
                '{1'b0, 1'b1, 2'd3, 1'b1, 3'd2, 2'd3, 2'd2, 32'hA2, 1'b0, 1'b0}};
    vecs[5] = '{'{1'b0, 3'd0, 1'b1, 32'hDEAD},
                '{1'b0, 1'b0, 2'd0, 1'b1, 3'd2, 2'd3, 2'd3, 32'hA3, 1'b1, 1'b1}};
    vecs[6] = '{'{1'b0, 3'd0, 1'b1, 32'hBEEF},
                '{1'b0, 1'b0, 2'd0, 1'b0, 3'd2, 2'd3, 2'd3, 32'hA3, 1'b0, 1'b0}};

    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset_outputs", 64'(observe()), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      bus_if.miss_req  = vecs[i].in.miss_req;
      bus_if.miss_set  = vecs[i].in.miss_set;
      bus_if.mem_valid = vecs[i].in.mem_valid;
      bus_if.mem_data  = vecs[i].in.mem_data;
      @(negedge clk);
      total++;
      if (observe() !== vecs[i].exp) begin
        $display("FAIL vec[%0d]: got %h, expected %h", i, observe(), vecs[i].exp);
      end else begin
        passed++;
      end
      next_cycle();
    end
    bus_if.mem_valid = 1'b0;

    // Set 2 ages now [1,2,3,0]: victim way 2, then ages [2,3,0,1].
    do_refill(3'd2, 2'd2, 32'hB0, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);

    // Hit way 1 -> [3,0,1,2]; next victim way 0, with a 3-cycle stall before word 1.
    bus_if.hit_valid = 1'b1;
    bus_if.hit_set   = 3'd2;
    bus_if.hit_way   = 2'd1;
    next_cycle();
    bus_if.hit_valid = 1'b0;
    do_refill(3'd2, 2'd0, 32'hC0, 3, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);

    // Set 2 ages [0,1,2,3]; a set-5 miss held throughout is acked only after done.
    do_refill(3'd2, 2'd3, 32'hD0, 0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd5);
    do_refill(3'd5, 2'd3, 32'hE0, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);

    // Reset after two words of a set-2 fill, with a miss still requested.
    bus_if.miss_req = 1'b1;
    bus_if.miss_set = 3'd2;
    @(negedge clk);
    chk("rst_seq_ack", 64'(bus_if.miss_ack), 64'd1);
    next_cycle();
    bus_if.mem_valid = 1'b1;
    bus_if.mem_data  = 32'h11;
    next_cycle();
    bus_if.mem_data  = 32'h22;
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'(observe()), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    bus_if.miss_req  = 1'b0;
    bus_if.mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_after_outputs", 64'(observe()), 64'd0);
    next_cycle();

    // Ages restored: victim way 3; a same-set hit in TAG is dropped.
    do_refill(3'd2, 2'd3, 32'hF0, 0, 1'b1, 3'd2, 2'd0, 1'b0, 3'd0);
    // Set 2 [1,2,3,0] -> victim way 2; hit on set 4 way 3 in TAG is applied.
    do_refill(3'd2, 2'd2, 32'h100, 0, 1'b1, 3'd4, 2'd3, 1'b0, 3'd0);
    do_refill(3'd4, 2'd2, 32'h200, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);
    do_refill(3'd2, 2'd1, 32'h300, 0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Refill controller for the set-associative cache data array. On a lookup miss it picks a victim way with per-set true-LRU ages, fetches the block word by word from the memory side, and drives the write strobe and address for the 32-bit data registers and the tag/valid write. It sits between the cache lookup logic, the memory interface and the register array; the set/way/word decode to per-register selects is external.

## Interface
- WAYS, 4, associativity (power of 2, ≥2)
- SETS, 8, number of sets (power of 2)
- WORDS, 4, 32-bit words per block (power of 2, ≥2)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- miss_req  in  1  miss request; held by requester until miss_ack
- miss_set  in  log2(SETS)  set index of the miss
- miss_ack  out  1  high in the cycle a miss is accepted
- hit_valid  in  1  lookup hit; touches LRU
- hit_set  in  log2(SETS)  set of the hit
- hit_way  in  log2(WAYS)  way of the hit
- mem_req  out  1  word fetch request
- mem_word  out  log2(WORDS)  word index requested
- mem_valid  in  1  mem_data valid for mem_word
- mem_data  in  32  fetched word
- regWrite  out  1  data-register write strobe, one cycle per word
- wr_set / wr_way / wr_word  out  log2(SETS)/log2(WAYS)/log2(WORDS)  target register select
- wr_data  out  32  data to write
- tag_write  out  1  tag/valid write strobe for (wr_set, wr_way)
- done  out  1  refill complete pulse

## Operation
- FSM: IDLE → FILL → TAG → IDLE.
- IDLE: miss_ack = miss_req (forced 0 while reset low). On accept: latch set, victim = way with age WAYS-1 in that set, word counter = 0, go FILL.
- FILL: mem_req=1, mem_word=counter. On mem_valid: wr_data←mem_data, wr_word←counter, regWrite←1 (registered, one cycle), counter++. Last word (counter=WORDS-1) → TAG. No mem_valid: mem_word held, regWrite 0.
- TAG: tag_write=1, done=1, mem_req=0; victim way touched in LRU; → IDLE.
- miss_req outside IDLE: not acknowledged, no effect. mem_valid outside FILL ignored.
- LRU: age per (set, way), log2(WAYS) bits, each set a permutation of 0..WAYS-1. Touch way w: every way with age < age[w] increments, age[w]←0. Reset ages: age[way i]=i, so initial victim is way WAYS-1.
- hit_valid touches LRU in any state. Same cycle as TAG touch on same set: TAG touch wins, hit dropped. Different set: both applied. Hit and miss accepted same cycle: victim taken from pre-touch ages, touch still applied.
- Reset mid-operation: refill abandoned, FSM IDLE, ages restored, no further strobes.

## Timing
- Reset values: miss_ack 0, mem_req 0, mem_word 0, regWrite 0, wr_set/wr_way/wr_word 0, wr_data 0, tag_write 0, done 0.
- Accept at cycle 0; mem_req from cycle 1. With mem_valid every cycle: words captured cycles 1..WORDS, regWrite cycles 2..WORDS+1, TAG (tag_write, done) cycle WORDS+1, next accept cycle WORDS+2.
- regWrite lags its mem_valid by exactly one cycle; wr_set/wr_way stable from cycle 1 until next accept.
- mem_req drops the cycle after the last mem_valid.

## Structure
- Package cache_pkg: WAYS, SETS, WORDS, derived widths, FSM state enum.
- Sub-module cache_lru_ages: age array, two touch ports (fill priority over hit), combinational victim lookup per set.

## Test plan
- Reset, miss set 2, mem_valid continuous, data 0xA0..0xA3 → ack cycle 0, regWrite cycles 2–5 way 3 words 0–3 with 0xA0..0xA3, tag_write/done cycle 5; set 2 ages [1,2,3,0].
- Second miss set 2 → victim way 2, ages [2,3,0,1]; hit set 2 way 1 → [3,0,1,2]; third miss → victim way 0.
- mem_valid low 3 cycles before word 1 → mem_word holds 1, no regWrite in gap, done 3 cycles later than baseline.
- miss_req set 5 held during set-2 refill → no ack until cycle after done, then victim way 3 of set 5.
- hit_valid set 2 way 0 in TAG cycle of set-2 way-3 fill → hit dropped, way 3 age 0; same with hit set 4 → both applied.
- Reset low after 2 words of a set-2 fill → all outputs 0 immediately; next miss set 2 victims way 3, full 4-word refill.
